pipelined_rca: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. Successor to the fixed-width single-cycle ripple-carry adder. Splits a WIDTH-bit add into SEG-bit ripple segments, with one register stage per segment and the carry registered between stages. It accepts one operation per cycle under a valid/ready handshake with full backpressure. It sits between operand producers and result consumers wherever the single-cycle carry chain no longer closes timing.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/full_adder.sv | 13 +
 rtl/rca_segment.sv | 32 +++
 rtl/pipelined_rca.sv | 129 ++++++++++++
 tb/tb_pipelined_rca.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: stage count and
// per-segment bit bounds, evaluated at elaboration time.
package adder_pkg;

  // Number of pipeline stages: one per SEG-bit slice, last slice may be short.
  function automatic int stages_f(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  // Lowest bit index covered by segment k.
  function automatic int seg_lo_f(input int k, input int seg);
    return k * seg;
  endfunction

  // Highest bit index covered by segment k, clipped to the operand width.
  function automatic int seg_hi_f(input int k, input int width, input int seg);
    int top;
    top = (k + 1) * seg;
    if (top > width) begin
      top = width;
    end
    return top - 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the building block of every ripple segment.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/rca_segment.sv
// Combinational N-bit ripple-carry chain. Also exposes the carry into the
// MSB so the final segment can derive two's-complement overflow.
module rca_segment #(
  parameter int N = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  // carry[i] is the carry into bit i; carry[N] leaves the segment
  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < N; gi++) begin : bit_g
    full_adder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (carry[gi]),
      .sum  (sum[gi]),
      .cout (carry[gi+1])
    );
  end

  assign cout     = carry[N];
  assign c_msb_in = carry[N-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor. Each stage adds one SEG-bit slice
// using the carry registered by the stage before it. Operand bits still to be
// added travel forward with the beat, finished sum bits accumulate behind it.
// A single global enable stalls the whole pipe when the consumer backs up.
module pipelined_rca
  import adder_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int SEG   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_ovf
);

  localparam int STAGES = stages_f(WIDTH, SEG);

  // Whole pipe advances together; bubbles are kept, never squeezed out.
  logic             adv;
  logic [WIDTH-1:0] b_eff;

  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  // Subtraction is A + ~B + 1: invert B here, the +1 enters as carry-in.
  assign b_eff = i_add_term2 ^ {WIDTH{i_sub}};

  for (genvar gi = 0; gi < STAGES; gi++) begin : stage_g
    localparam int LO = seg_lo_f(gi, SEG);
    localparam int HI = seg_hi_f(gi, WIDTH, SEG);
    localparam int N  = HI - LO + 1;

    // Operand bits from this segment upward, as seen by this stage
    logic [WIDTH-1:LO] a_src;
    logic [WIDTH-1:LO] b_src;
    logic              valid_d;
    logic              cin_d;
    logic [N-1:0]      seg_s;
    logic              seg_co;
    logic              seg_cm;
    logic [HI:0]       sum_d;

    logic              valid_q;
    logic              carry_q;
    logic [HI:0]       sum_q;

    if (gi == 0) begin : src_g
      assign valid_d = i_valid;
      assign cin_d   = i_sub;
      assign a_src   = i_add_term1;
      assign b_src   = b_eff;
      assign sum_d   = seg_s;
    end else begin : src_g
      assign valid_d = stage_g[gi-1].valid_q;
      assign cin_d   = stage_g[gi-1].carry_q;
      assign a_src   = stage_g[gi-1].fwd_g.a_q;
      assign b_src   = stage_g[gi-1].fwd_g.b_q;
      assign sum_d   = {seg_s, stage_g[gi-1].sum_q};
    end

    rca_segment #(
      .N (N)
    ) u_seg (
      .a        (a_src[HI:LO]),
      .b        (b_src[HI:LO]),
      .cin      (cin_d),
      .sum      (seg_s),
      .cout     (seg_co),
      .c_msb_in (seg_cm)
    );

    // Stage register: valid flag, segment carry-out and accumulated sum bits
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_d;
        carry_q <= seg_co;
        sum_q   <= sum_d;
      end
    end

    // Skew registers carry the not-yet-added operand bits to later stages
    if (gi < STAGES - 1) begin : fwd_g
      logic [WIDTH-1:HI+1] a_q;
      logic [WIDTH-1:HI+1] b_q;

      // Forward remaining operand bits alongside the beat
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[WIDTH-1:HI+1];
          b_q <= b_src[WIDTH-1:HI+1];
        end
      end
    end

    // Only the top segment sees the sign bit, so overflow is resolved here
    if (gi == STAGES - 1) begin : ovf_g
      logic ovf_q;

      // Signed overflow: carry into the MSB differs from carry out of it
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= seg_co ^ seg_cm;
        end
      end
    end
  end

  assign o_valid  = stage_g[STAGES-1].valid_q;
  assign o_result = {stage_g[STAGES-1].carry_q, stage_g[STAGES-1].sum_q};
  assign o_ovf    = stage_g[STAGES-1].ovf_g.ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Testbench for pipelined_rca: directed vectors, backpressure, reset in
// flight and randomized streams over four width/segment configurations.
module tb_pipelined_rca;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic        sub_bus;
  logic [3:0]  vin;
  logic [3:0]  rin;
  wire  [3:0]  vout;
  wire  [3:0]  rdy;
  wire  [3:0]  ovf;
  wire  [7:0]  res0;
  wire  [16:0] res1;
  wire  [8:0]  res2;
  wire  [1:0]  res3;
  logic [16:0] res_w [4];

  int tests_run    = 0;
  int tests_failed = 0;

  assign res_w[0] = {9'd0, res0};
  assign res_w[1] = res1;
  assign res_w[2] = {8'd0, res2};
  assign res_w[3] = {15'd0, res3};

  pipelined_rca #(.WIDTH(7), .SEG(3)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(vin[0]), .o_ready(rdy[0]),
    .i_add_term1(a_bus[6:0]), .i_add_term2(b_bus[6:0]), .i_sub(sub_bus),
    .o_valid(vout[0]), .i_ready(rin[0]), .o_result(res0), .o_ovf(ovf[0]));

  pipelined_rca #(.WIDTH(16), .SEG(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(vin[1]), .o_ready(rdy[1]),
    .i_add_term1(a_bus), .i_add_term2(b_bus), .i_sub(sub_bus),
    .o_valid(vout[1]), .i_ready(rin[1]), .o_result(res1), .o_ovf(ovf[1]));

  pipelined_rca #(.WIDTH(8), .SEG(8)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(vin[2]), .o_ready(rdy[2]),
    .i_add_term1(a_bus[7:0]), .i_add_term2(b_bus[7:0]), .i_sub(sub_bus),
    .o_valid(vout[2]), .i_ready(rin[2]), .o_result(res2), .o_ovf(ovf[2]));

  pipelined_rca #(.WIDTH(1), .SEG(1)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(vin[3]), .o_ready(rdy[3]),
    .i_add_term1(a_bus[0:0]), .i_add_term2(b_bus[0:0]), .i_sub(sub_bus),
    .o_valid(vout[3]), .i_ready(rin[3]), .o_result(res3), .o_ovf(ovf[3]));

  function automatic int width_of(input int c);
    case (c)
      0:       return 7;
      1:       return 16;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer arithmetic. Returns {ovf, result[16:0]}.
  function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic sub);
    longint one, full, half, ua, ub, sa, sb, r, t;
    logic   o;
    one  = 1;
    full = one << w;
    half = one << (w - 1);
    ua = 0;
    ub = 0;
    ua[15:0] = a;
    ub[15:0] = b;
    ua = ua & (full - 1);
    ub = ub & (full - 1);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    r  = sub ? (ua - ub + full) : (ua + ub);
    t  = sub ? (sa - sb) : (sa + sb);
    o  = (t < -half) || (t >= half);
    return {o, r[16:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    vin = 4'h0;
    rin = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (vout[c] !== 1'b0 || res_w[c] !== 17'd0 || ovf[c] !== 1'b0 || rdy[c] !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d: got valid=%b res=%h ovf=%b rdy=%b want 0/0/0/1",
                 c, vout[c], res_w[c], ovf[c], rdy[c]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (rdy !== 4'hF || vout !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_release: got rdy=%b valid=%b want 1111/0000", rdy, vout);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    logic [6:0] ta [5];
    logic [6:0] tb [5];
    logic       ts [5];
    logic [7:0] tr [5];
    logic       to [5];
    ta = '{7'd127, 7'd5, 7'd7, 7'd63, 7'd64};
    tb = '{7'd127, 7'd7, 7'd5, 7'd1,  7'd1};
    ts = '{1'b0,   1'b1, 1'b1, 1'b0,  1'b1};
    tr = '{8'hFE,  8'h7E, 8'h82, 8'h40, 8'hBF};
    to = '{1'b0,   1'b0,  1'b0,  1'b1,  1'b1};
    rin[0] = 1'b1;
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      a_bus   = {9'd0, ta[v]};
      b_bus   = {9'd0, tb[v]};
      sub_bus = ts[v];
      vin[0]  = 1'b1;
      @(posedge clk);
      #1;
      vin[0] = 1'b0;
      for (int e = 1; e <= 3; e++) begin
        if (e > 1) begin
          @(posedge clk);
          #1;
        end
        tests_run++;
        if (vout[0] !== (e == 3)) begin
          tests_failed++;
          $display("FAIL latency vec%0d edge%0d: got valid=%b want %b", v, e, vout[0], (e == 3));
        end
      end
      tests_run++;
      if (res0 !== tr[v] || ovf[0] !== to[v]) begin
        tests_failed++;
        $display("FAIL directed vec%0d: got res=%h ovf=%b want res=%h ovf=%b",
                 v, res0, ovf[0], tr[v], to[v]);
      end
      $display("[TB] directed A=%0d B=%0d sub=%b -> res=%h ovf=%b", ta[v], tb[v], ts[v], res0, ovf[0]);
      @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] q [$];
    logic [17:0] exp;
    logic [7:0]  res_prev;
    logic        ovf_prev;
    logic        stalled_prev;
    logic        holding;
    int          sent;
    int          got;
    sent = 0;
    got = 0;
    stalled_prev = 1'b0;
    holding = 1'b0;
    res_prev = '0;
    ovf_prev = 1'b0;
    for (int i = 0; i < 40 && got < 6; i++) begin
      @(negedge clk);
      if (stalled_prev) begin
        tests_run++;
        if (res0 !== res_prev || ovf[0] !== ovf_prev || vout[0] !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_stable cyc%0d: got res=%h ovf=%b valid=%b want res=%h ovf=%b valid=1",
                   i, res0, ovf[0], vout[0], res_prev, ovf_prev);
        end
      end
      if (!holding && sent < 6) begin
        a_bus   = 16'($urandom);
        b_bus   = 16'($urandom);
        sub_bus = 1'($urandom);
      end
      vin[0] = (sent < 6);
      rin[0] = !(i >= 4 && i < 8);
      #1;
      tests_run++;
      if (rdy[0] !== !(vout[0] && !rin[0])) begin
        tests_failed++;
        $display("FAIL bp_ready cyc%0d: got %b want %b", i, rdy[0], !(vout[0] && !rin[0]));
      end
      if (vout[0] && rin[0]) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL bp_spurious cyc%0d: got res=%h want no beat", i, res0);
        end else begin
          exp = q.pop_front();
          if (res0 !== exp[7:0] || ovf[0] !== exp[17]) begin
            tests_failed++;
            $display("FAIL bp_result beat%0d: got res=%h ovf=%b want res=%h ovf=%b",
                     got, res0, ovf[0], exp[7:0], exp[17]);
          end
          $display("[TB] bp beat %0d res=%h ovf=%b", got, res0, ovf[0]);
        end
        got++;
      end
      if (vin[0] && rdy[0]) begin
        q.push_back(model(7, a_bus, b_bus, sub_bus));
        sent++;
        holding = 1'b0;
      end else begin
        holding = vin[0];
      end
      stalled_prev = vout[0] && !rin[0];
      res_prev = res0;
      ovf_prev = ovf[0];
    end
    vin[0] = 1'b0;
    rin[0] = 1'b1;
    tests_run++;
    if (got != 6 || q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d beats (%0d pending) want 6 (0 pending)", got, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    rin[0]  = 1'b0;
    a_bus   = 16'd127;
    b_bus   = 16'd127;
    sub_bus = 1'b0;
    vin[0]  = 1'b1;
    @(negedge clk);
    a_bus   = 16'd63;
    b_bus   = 16'd1;
    @(negedge clk);
    vin[0] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (vout[0] !== 1'b1 || res0 !== 8'hFE) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got valid=%b res=%h want 1/fe", vout[0], res0);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (vout[0] !== 1'b0 || res0 !== 8'h00 || ovf[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: got valid=%b res=%h ovf=%b rdy=%b want 0/00/0/1",
               vout[0], res0, ovf[0], rdy[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    rin[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (vout[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_mid_stale cyc%0d: got valid=%b res=%h want valid=0", i, vout[0], res0);
      end
    end
    @(negedge clk);
    a_bus   = 16'd7;
    b_bus   = 16'd5;
    sub_bus = 1'b1;
    vin[0]  = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      vin[0] = 1'b0;
      tests_run++;
      if (vout[0] !== (e == 3)) begin
        tests_failed++;
        $display("FAIL rst_mid_latency edge%0d: got valid=%b want %b", e, vout[0], (e == 3));
      end
    end
    tests_run++;
    if (res0 !== 8'h82 || ovf[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_result: got res=%h ovf=%b want 82/0", res0, ovf[0]);
    end
    $display("[TB] reset mid-stream: post-reset beat res=%h", res0);
    @(posedge clk);
  endtask

  task automatic test_random(input int c, input int nbeats);
    logic [17:0] q [$];
    logic [17:0] exp;
    logic [16:0] res_prev;
    logic        ovf_prev;
    logic        stalled_prev;
    logic        holding;
    int          sent;
    int          got;
    int          cycles;
    int          w;
    int          errs_before;
    w = width_of(c);
    sent = 0;
    got = 0;
    cycles = 0;
    stalled_prev = 1'b0;
    holding = 1'b0;
    res_prev = '0;
    ovf_prev = 1'b0;
    errs_before = tests_failed;
    while (got < nbeats && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (stalled_prev) begin
        tests_run++;
        if (res_w[c] !== res_prev || ovf[c] !== ovf_prev || vout[c] !== 1'b1) begin
          tests_failed++;
          $display("FAIL rnd_stable dut%0d cyc%0d: got res=%h ovf=%b want res=%h ovf=%b",
                   c, cycles, res_w[c], ovf[c], res_prev, ovf_prev);
        end
      end
      if (!holding) begin
        a_bus   = 16'($urandom);
        b_bus   = 16'($urandom);
        sub_bus = 1'($urandom);
        vin[c]  = (sent < nbeats) && ($urandom_range(3) != 0);
      end
      rin[c] = ($urandom_range(3) != 0);
      #1;
      tests_run++;
      if (rdy[c] !== (!vout[c] || rin[c])) begin
        tests_failed++;
        $display("FAIL rnd_ready dut%0d cyc%0d: got %b want %b", c, cycles, rdy[c], (!vout[c] || rin[c]));
      end
      if (vout[c] && rin[c]) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL rnd_spurious dut%0d cyc%0d: got res=%h want no beat", c, cycles, res_w[c]);
        end else begin
          exp = q.pop_front();
          if (res_w[c] !== exp[16:0] || ovf[c] !== exp[17]) begin
            tests_failed++;
            $display("FAIL rnd_result dut%0d beat%0d: got res=%h ovf=%b want res=%h ovf=%b",
                     c, got, res_w[c], ovf[c], exp[16:0], exp[17]);
          end
        end
        got++;
      end
      if (vin[c] && rdy[c]) begin
        q.push_back(model(w, a_bus, b_bus, sub_bus));
        sent++;
        holding = 1'b0;
      end else begin
        holding = vin[c];
      end
      stalled_prev = vout[c] && !rin[c];
      res_prev = res_w[c];
      ovf_prev = ovf[c];
    end
    vin[c] = 1'b0;
    rin[c] = 1'b1;
    tests_run++;
    if (got != nbeats || q.size() != 0) begin
      tests_failed++;
      $display("FAIL rnd_count dut%0d: got %0d beats (%0d pending) want %0d (0 pending)",
               c, got, q.size(), nbeats);
    end
    $display("[TB] random WIDTH=%0d: %0d beats in %0d cycles, %0d errors",
             w, got, cycles, tests_failed - errs_before);
  endtask

  initial begin
    rst     = 1'b1;
    vin     = 4'h0;
    rin     = 4'hF;
    a_bus   = '0;
    b_bus   = '0;
    sub_bus = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    for (int c = 0; c < 4; c++) begin
      test_random(c, 2500);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
